// File: rtl/othello_move_sequencer.sv
// othello_move_sequencer
// Plays one Othello move on an internal 8x8 board. A start pulse in IDLE latches
// the mover and target; the target is checked, all eight directions are scanned,
// every bracketed opponent disc is flipped (one draw handshake per cell) and
// finally the mover's disc is placed.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   new_game                 : reload the opening board (IDLE only)
//   start, side, cur_x/y     : move request, mover (0 black, 1 white), target cell
//   busy, done               : move in progress / one-cycle completion pulse
//   valid_move, flip_count   : result of the last move, held until the next start
//   draw_req/ack, draw_x/y/sel : redraw handshake towards the plot helper
//   rd_x, rd_y, rd_cell      : combinational board read port
module othello_move_sequencer #(
   parameter logic [1:0] SEL_BLACK = 2'd1,
   parameter logic [1:0] SEL_WHITE = 2'd2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       new_game,
   input  logic       start,
   input  logic       side,
   input  logic [2:0] cur_x,
   input  logic [2:0] cur_y,
   output logic       busy,
   output logic       done,
   output logic       valid_move,
   output logic [4:0] flip_count,
   output logic       draw_req,
   input  logic       draw_ack,
   output logic [2:0] draw_x,
   output logic [2:0] draw_y,
   output logic [1:0] draw_sel,
   input  logic [2:0] rd_x,
   input  logic [2:0] rd_y,
   output logic [1:0] rd_cell
);

   typedef enum logic [2:0] {
      StIdle, StCheck, StScan, StFlip, StNextDir, StPlace, StDone
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] board_q [64];   // index = {y, x}
   logic       side_q, side_d;
   logic [2:0] tx_q, tx_d, ty_q, ty_d;
   logic [2:0] px_q, px_d, py_q, py_d;
   logic [2:0] dir_q, dir_d, run_q, run_d;
   logic [4:0] flips_q, flips_d;
   logic       valid_q, valid_d;
   logic       board_we, board_load;
   logic [3:0] step_x, step_y, nx, ny;
   logic [1:0] own, opp, next_cell;
   logic       next_off;

   // Direction deltas as 4-bit two's complement; order N, NE, E, SE, S, SW, W, NW.
   always_comb begin
      step_x = 4'd0;
      step_y = 4'd0;
      case (dir_q)
         3'd0:    begin step_x = 4'd0;  step_y = 4'hF; end
         3'd1:    begin step_x = 4'd1;  step_y = 4'hF; end
         3'd2:    begin step_x = 4'd1;  step_y = 4'd0; end
         3'd3:    begin step_x = 4'd1;  step_y = 4'd1; end
         3'd4:    begin step_x = 4'd0;  step_y = 4'd1; end
         3'd5:    begin step_x = 4'hF;  step_y = 4'd1; end
         3'd6:    begin step_x = 4'hF;  step_y = 4'd0; end
         default: begin step_x = 4'hF;  step_y = 4'hF; end
      endcase
   end

   // A 4-bit step leaves the board exactly when bit 3 is set (-1 or 8), so no wrap.
   assign nx        = {1'b0, px_q} + step_x;
   assign ny        = {1'b0, py_q} + step_y;
   assign next_off  = nx[3] | ny[3];
   assign next_cell = board_q[{ny[2:0], nx[2:0]}];
   assign own       = side_q ? 2'b10 : 2'b01;
   assign opp       = side_q ? 2'b01 : 2'b10;

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign valid_move = valid_q;
   assign flip_count = flips_q;
   assign draw_req   = (state_q == StFlip) || ((state_q == StPlace) && (flips_q != 5'd0));
   assign draw_x     = draw_req ? px_q : 3'd0;
   assign draw_y     = draw_req ? py_q : 3'd0;
   assign draw_sel   = draw_req ? (side_q ? SEL_WHITE : SEL_BLACK) : 2'b00;
   assign rd_cell    = board_q[{rd_y, rd_x}];

   always_comb begin
      state_d    = state_q;
      side_d     = side_q;
      tx_d       = tx_q;
      ty_d       = ty_q;
      px_d       = px_q;
      py_d       = py_q;
      dir_d      = dir_q;
      run_d      = run_q;
      flips_d    = flips_q;
      valid_d    = valid_q;
      board_we   = 1'b0;
      board_load = 1'b0;
      case (state_q)
         StIdle: begin
            if (new_game) begin
               board_load = 1'b1;
            end else if (start) begin
               side_d  = side;
               tx_d    = cur_x;
               ty_d    = cur_y;
               px_d    = cur_x;
               py_d    = cur_y;
               flips_d = 5'd0;
               valid_d = 1'b0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (board_q[{ty_q, tx_q}] != 2'b00) begin
               state_d = StDone;
            end else begin
               dir_d   = 3'd0;
               run_d   = 3'd0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (next_off || next_cell == 2'b00) begin
               state_d = StNextDir;
            end else if (next_cell == opp) begin
               run_d = run_q + 3'd1;
               px_d  = nx[2:0];
               py_d  = ny[2:0];
            end else if (run_q == 3'd0) begin
               state_d = StNextDir;
            end else begin
               // Position already sits on the last opponent disc of the run.
               state_d = StFlip;
            end
         end
         StFlip: begin
            if (draw_ack) begin
               board_we = 1'b1;
               flips_d  = flips_q + 5'd1;
               run_d    = run_q - 3'd1;
               px_d     = px_q - step_x[2:0];
               py_d     = py_q - step_y[2:0];
               if (run_q == 3'd1) begin
                  state_d = StNextDir;
               end
            end
         end
         StNextDir: begin
            run_d = 3'd0;
            px_d  = tx_q;
            py_d  = ty_q;
            if (dir_q == 3'd7) begin
               state_d = StPlace;
            end else begin
               dir_d   = dir_q + 3'd1;
               state_d = StScan;
            end
         end
         StPlace: begin
            if (flips_q == 5'd0) begin
               state_d = StDone;
            end else if (draw_ack) begin
               board_we = 1'b1;
               valid_d  = 1'b1;
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         side_q  <= 1'b0;
         tx_q    <= 3'd0;
         ty_q    <= 3'd0;
         px_q    <= 3'd0;
         py_q    <= 3'd0;
         dir_q   <= 3'd0;
         run_q   <= 3'd0;
         flips_q <= 5'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         px_q    <= px_d;
         py_q    <= py_d;
         dir_q   <= dir_d;
         run_q   <= run_d;
         flips_q <= flips_d;
         valid_q <= valid_d;
      end
   end

   // Writes always target the current position (flipped disc or the target cell).
   always_ff @(posedge clock) begin
      if (reset || board_load) begin
         for (int i = 0; i < 64; i++) begin
            board_q[i] <= 2'b00;
         end
         board_q[27] <= 2'b10;   // (3,3) white
         board_q[36] <= 2'b10;   // (4,4) white
         board_q[35] <= 2'b01;   // (3,4) black
         board_q[28] <= 2'b01;   // (4,3) black
      end else if (board_we) begin
         board_q[{py_q, px_q}] <= own;
      end
   end

endmodule
